icache_data_assoc: RTL

- Set-associative instruction-cache data array; parametrised successor to the direct-mapped single-line-write data RAM.
- Adds ways, multi-beat line fill through a staging buffer with a fill FSM, fill abort, and commit-cycle read bypass.
- Sits between IFetch2 (read side: set from paddr, way from tag compare) and L1ICtrl (fill side: beats from the memory interface).

---
 rtl/icache_data_assoc.sv | 134 +++++++++++++
 1 files changed

// File: rtl/icache_data_assoc.sv
// Set-associative I-cache data array: 1R1W line storage, multi-beat fill through a
// staging buffer with abort, and a read bypass of the staged line during commit.
module icache_data_assoc #(
   parameter int NUM_WAYS            = 2,
   parameter int NUM_WAYS_BITS       = 1,
   parameter int NUM_SETS            = 32,
   parameter int NUM_SETS_BITS       = 5,
   parameter int CACHELINE_SIZE_BITS = 4,
   parameter int BEAT_WIDTH          = 64,
   parameter int PADDR_WIDTH         = 32,
   localparam int LW                 = 8 << CACHELINE_SIZE_BITS
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_read,
   input  logic [PADDR_WIDTH-1:0]   i_read_paddr,
   input  logic [NUM_WAYS_BITS-1:0] i_read_way,
   output logic [LW-1:0]            o_data,
   output logic                     o_data_valid,
   input  logic                     i_fill_start,
   input  logic [PADDR_WIDTH-1:0]   i_fill_paddr,
   input  logic [NUM_WAYS_BITS-1:0] i_fill_way,
   output logic                     o_fill_ready,
   input  logic                     i_beat_valid,
   input  logic [BEAT_WIDTH-1:0]    i_beat_data,
   input  logic                     i_fill_abort,
   output logic                     o_fill_done
);

   localparam int NUM_BEATS = LW / BEAT_WIDTH;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int SET_LO    = CACHELINE_SIZE_BITS;
   localparam int SET_HI    = CACHELINE_SIZE_BITS + NUM_SETS_BITS - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   state_e                               state_q;
   logic [CNT_W-1:0]                     cnt_q;
   logic [NUM_SETS_BITS-1:0]             fill_set_q;
   logic [NUM_WAYS_BITS-1:0]             fill_way_q;
   logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] staging_q;
   logic [LW-1:0]                        mem_q [NUM_WAYS][NUM_SETS];
   logic [LW-1:0]                        data_q;
   logic                                 data_valid_q;

   logic [NUM_SETS_BITS-1:0] read_set;
   logic                     read_hits_fill;
   logic                     last_beat;
   logic                     beat_accept;
   logic                     unused_paddr_bits;

   assign read_set       = i_read_paddr[SET_HI:SET_LO];
   assign read_hits_fill = (read_set == fill_set_q) && (i_read_way == fill_way_q);
   assign last_beat      = (cnt_q == CNT_W'(NUM_BEATS - 1));
   assign beat_accept    = (state_q == FILL) && i_beat_valid && !i_fill_abort;

   assign unused_paddr_bits = ^{i_read_paddr[PADDR_WIDTH-1:SET_HI+1], i_read_paddr[SET_LO-1:0],
                                i_fill_paddr[PADDR_WIDTH-1:SET_HI+1], i_fill_paddr[SET_LO-1:0]};

   assign o_fill_ready = (state_q == IDLE);
   assign o_fill_done  = (state_q == COMMIT);
   assign o_data       = data_q;
   assign o_data_valid = data_valid_q;

   // Fill sequencing; the counter parks on the last beat instead of wrapping.
   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_fill_start) begin
                  state_q <= FILL;
                  cnt_q   <= '0;
               end
            end
            FILL: begin
               if (i_fill_abort) begin
                  state_q <= IDLE;
               end else if (i_beat_valid) begin
                  if (last_beat) state_q <= COMMIT;
                  else           cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            COMMIT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: array, staging buffer and latched fill target carry no reset; their
   // contents are only ever consumed after being written by a fill.
   always_ff @(posedge i_clk) begin
      if (state_q == IDLE && i_fill_start) begin
         fill_set_q <= i_fill_paddr[SET_HI:SET_LO];
         fill_way_q <= i_fill_way;
      end
      if (beat_accept) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) staging_q[b] <= i_beat_data;
         end
      end
      if (state_q == COMMIT && !i_rst) begin
         mem_q[fill_way_q][fill_set_q] <= staging_q;
      end
   end

   // Read port: the array read returns pre-write contents, so the committing line
   // is forwarded from staging and a line under replacement reads as invalid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q       <= '0;
         data_valid_q <= 1'b0;
      end else if (!i_read) begin
         data_valid_q <= 1'b0;
      end else if (state_q == COMMIT && read_hits_fill) begin
         data_q       <= staging_q;
         data_valid_q <= 1'b1;
      end else if (state_q == FILL && read_hits_fill) begin
         data_valid_q <= 1'b0;
      end else begin
         data_q       <= mem_q[i_read_way][read_set];
         data_valid_q <= 1'b1;
      end
   end

endmodule
